// File: rtl/bkram_sd_streamer.sv
// Backup RAM <-> SD save image streamer.
// Moves the 32 KB cartridge nvram to and from the mounted SD save image one
// 512-byte sector at a time. It issues sd_rd/sd_wr sector requests to user_io
// and shuttles sector bytes between the user_io buffer and nvram port B.
module bkram_sd_streamer #(
  parameter int SECT_W = 6,
  parameter int SLOT_W = 2,
  parameter int TMO_W  = 24
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                img_mounted,
  input  logic [31:0]         img_size,
  input  logic                bk_load,
  input  logic                bk_save,
  input  logic [SLOT_W-1:0]   slot,
  output logic [31:0]         sd_lba,
  output logic                sd_rd,
  output logic                sd_wr,
  input  logic                sd_ack,
  input  logic [8:0]          sd_buff_addr,
  input  logic [7:0]          sd_buff_dout,
  input  logic                sd_buff_wr,
  output logic [7:0]          sd_buff_din,
  output logic [SECT_W+8:0]   nv_addr,
  output logic                nv_we,
  output logic [7:0]          nv_d,
  input  logic [7:0]          nv_q,
  output logic                bk_ena,
  output logic                bk_busy,
  output logic                bk_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER
  } state_t;

  state_t            state;
  logic              loading;
  logic              load_d;
  logic              save_d;
  logic              dl_d;
  logic              ack_d;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              load_lvl;
  logic              save_lvl;
  logic              load_trig;
  logic              save_trig;
  logic              ack_rise;
  logic              ack_fall;
  logic              last_sect;
  logic [31:0]       slot_base;

  // Trigger levels only count while a save image is present; edges are
  // detected against the copies registered one cycle earlier.
  assign load_lvl  = bk_load & bk_ena;
  assign save_lvl  = bk_save & bk_ena;
  assign load_trig = load_lvl & ~load_d;
  assign save_trig = save_lvl & ~save_d;
  assign ack_rise  = sd_ack & ~ack_d;
  assign ack_fall  = ~sd_ack & ack_d;
  assign last_sect = &sd_lba[SECT_W-1:0];
  assign slot_base = {{(32-SLOT_W-SECT_W){1'b0}}, slot, {SECT_W{1'b0}}};

  // Sector bytes map straight onto nvram: the sector number within the slot
  // selects the 512-byte page, the buffer index selects the byte.
  assign nv_addr     = {sd_lba[SECT_W-1:0], sd_buff_addr};
  assign nv_d        = sd_buff_dout;
  assign nv_we       = sd_buff_wr & sd_ack & loading & (state == ST_XFER);
  assign sd_buff_din = nv_q;

  // Delayed copies of the trigger levels, download flag and sd_ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_d <= 1'b0;
      save_d <= 1'b0;
      dl_d   <= 1'b0;
      ack_d  <= 1'b0;
    end else begin
      load_d <= load_lvl;
      save_d <= save_lvl;
      dl_d   <= ioctl_download;
      ack_d  <= sd_ack;
    end
  end

  // A new download invalidates the save image until a mount is seen during it;
  // a mount in the same cycle as the download edge keeps the image enabled.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bk_ena <= 1'b0;
    end else if (ioctl_download && img_mounted && (img_size != 32'd0)) begin
      bk_ena <= 1'b1;
    end else if (ioctl_download && !dl_d) begin
      bk_ena <= 1'b0;
    end
  end

  // Sector sequencer: request a sector, wait for user_io to move it, advance
  // to the next sector of the slot until the last one is done.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= ST_IDLE;
      loading <= 1'b0;
      bk_busy <= 1'b0;
      bk_err  <= 1'b0;
      sd_lba  <= 32'd0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_trig || save_trig) begin
            loading <= load_trig;
            bk_busy <= 1'b1;
            bk_err  <= 1'b0;
            sd_lba  <= slot_base;
            sd_rd   <= load_trig;
            sd_wr   <= ~load_trig;
            tmo_cnt <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_rise) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            tmo_cnt <= '0;
            state   <= ST_XFER;
          end else if (&tmo_cnt) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            bk_err  <= 1'b1;
            bk_busy <= 1'b0;
            tmo_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_XFER: begin
          if (ack_fall) begin
            if (last_sect) begin
              bk_busy <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              sd_lba[SECT_W-1:0] <= sd_lba[SECT_W-1:0] + SECT_W'(1);
              sd_rd   <= loading;
              sd_wr   <= ~loading;
              tmo_cnt <= '0;
              state   <= ST_REQ;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
